// File: rtl/serv_dbus_periph.sv
`default_nettype none
// ============================================================================
//  Module   : serv_dbus_periph
//  Purpose  : Data-bus responder for the SERV core. Every dbus cycle gets a
//             one-clock ack and registered read data. The responder holds a
//             GPIO output register, a synchronized GPIO input, a 64-bit
//             prescaled mtime/mtimecmp timer, a control register, and the
//             level timer interrupt that goes back to the core.
//
//  Ports    : clk          system clock, all state on the rising edge
//             i_rst        asynchronous active-high reset
//             i_dbus_adr   byte address (adr[SEL_BIT] = window hit, adr[4:2] = index)
//             i_dbus_dat   write data
//             i_dbus_sel   byte enables, bit n covers dat[8n+7:8n]
//             i_dbus_we    1 = write, 0 = read
//             i_dbus_cyc   cycle request, held until ack
//             o_dbus_rdt   read data, zero whenever ack is low
//             o_dbus_ack   one-clock completion pulse
//             i_gpio       asynchronous pin inputs
//             o_gpio       GPIO output register
//             o_timer_irq  level timer interrupt
//
//  Revision : 1.0  initial release
// ============================================================================
module serv_dbus_periph #(
    parameter int GPIO_W   = 3,
    parameter int SEL_BIT  = 8,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [31:0]       i_dbus_adr,
    input  logic [31:0]       i_dbus_dat,
    input  logic [3:0]        i_dbus_sel,
    input  logic              i_dbus_we,
    input  logic              i_dbus_cyc,
    output logic [31:0]       o_dbus_rdt,
    output logic              o_dbus_ack,
    input  logic [GPIO_W-1:0] i_gpio,
    output logic [GPIO_W-1:0] o_gpio,
    output logic              o_timer_irq
);

    localparam int                c_ps_w    = $clog2(PRESCALE + 1);
    localparam logic [c_ps_w-1:0] c_ps_last = c_ps_w'(PRESCALE - 1);

    localparam logic [2:0] c_idx_gpio_out = 3'd0;
    localparam logic [2:0] c_idx_gpio_in  = 3'd1;
    localparam logic [2:0] c_idx_mtime_lo = 3'd2;
    localparam logic [2:0] c_idx_mtime_hi = 3'd3;
    localparam logic [2:0] c_idx_mtcmp_lo = 3'd4;
    localparam logic [2:0] c_idx_mtcmp_hi = 3'd5;
    localparam logic [2:0] c_idx_ctrl     = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_ack;
    logic [31:0]       r_rdt;
    logic [GPIO_W-1:0] r_gpio_out;
    logic [GPIO_W-1:0] r_gpio_s1;
    logic [GPIO_W-1:0] r_gpio_s2;
    logic [63:0]       r_mtime;
    logic [63:0]       r_mtimecmp;
    logic              r_timer_en;
    logic              r_irq_en;
    logic [c_ps_w-1:0] r_ps;
    logic              r_irq;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic        w_commit;
    logic        w_hit;
    logic [2:0]  w_idx;
    logic        w_wr;
    logic [31:0] w_bmask;
    logic        w_wr_gpio;
    logic        w_wr_mtlo;
    logic        w_wr_mthi;
    logic        w_wr_cmlo;
    logic        w_wr_cmhi;
    logic        w_wr_ctrl;

    // The commit edge is the one that raises ack; the toggle guarantees a
    // cycle held across two clocks commits only once.
    assign w_commit  = i_dbus_cyc & ~r_ack;
    assign w_hit     = i_dbus_adr[SEL_BIT];
    assign w_idx     = i_dbus_adr[4:2];
    assign w_wr      = w_commit & w_hit & i_dbus_we;
    assign w_bmask   = {{8{i_dbus_sel[3]}}, {8{i_dbus_sel[2]}},
                        {8{i_dbus_sel[1]}}, {8{i_dbus_sel[0]}}};

    assign w_wr_gpio = w_wr & (w_idx == c_idx_gpio_out);
    assign w_wr_mtlo = w_wr & (w_idx == c_idx_mtime_lo);
    assign w_wr_mthi = w_wr & (w_idx == c_idx_mtime_hi);
    assign w_wr_cmlo = w_wr & (w_idx == c_idx_mtcmp_lo);
    assign w_wr_cmhi = w_wr & (w_idx == c_idx_mtcmp_hi);
    assign w_wr_ctrl = w_wr & (w_idx == c_idx_ctrl) & i_dbus_sel[0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    logic [31:0] w_gpio_wdata;
    assign w_gpio_wdata = merge_bytes(32'(r_gpio_out), i_dbus_dat, w_bmask);

    // ------------------------------------------------------------------
    // Timer next-state
    // ------------------------------------------------------------------
    logic              w_tick;
    logic [c_ps_w-1:0] w_ps_nxt;
    logic [63:0]       w_mtime_nxt;
    logic [63:0]       w_mtimecmp_nxt;

    assign w_tick = r_timer_en & (r_ps == c_ps_last);

    always_comb begin
        w_ps_nxt = r_ps;
        if (!r_timer_en || w_tick) begin
            w_ps_nxt = '0;
        end else begin
            w_ps_nxt = r_ps + c_ps_w'(1);
        end
    end

    // A bus write to either half overrides the increment on the same edge;
    // the written half takes the (byte-merged) bus value, the other half keeps
    // its pre-edge value so no carry crosses the halves.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
        if (w_wr_mtlo) begin
            w_mtime_nxt = {r_mtime[63:32],
                           merge_bytes(r_mtime[31:0], i_dbus_dat, w_bmask)};
        end else if (w_wr_mthi) begin
            w_mtime_nxt = {merge_bytes(r_mtime[63:32], i_dbus_dat, w_bmask),
                           r_mtime[31:0]};
        end
    end

    always_comb begin
        w_mtimecmp_nxt = r_mtimecmp;
        if (w_wr_cmlo) begin
            w_mtimecmp_nxt[31:0]  = merge_bytes(r_mtimecmp[31:0], i_dbus_dat, w_bmask);
        end
        if (w_wr_cmhi) begin
            w_mtimecmp_nxt[63:32] = merge_bytes(r_mtimecmp[63:32], i_dbus_dat, w_bmask);
        end
    end

    // ------------------------------------------------------------------
    // Read mux (pre-write state)
    // ------------------------------------------------------------------
    logic [31:0] w_rd_data;

    always_comb begin
        w_rd_data = 32'd0;
        if (w_hit) begin
            case (w_idx)
                c_idx_gpio_out: w_rd_data = 32'(r_gpio_out);
                c_idx_gpio_in:  w_rd_data = 32'(r_gpio_s2);
                c_idx_mtime_lo: w_rd_data = r_mtime[31:0];
                c_idx_mtime_hi: w_rd_data = r_mtime[63:32];
                c_idx_mtcmp_lo: w_rd_data = r_mtimecmp[31:0];
                c_idx_mtcmp_hi: w_rd_data = r_mtimecmp[63:32];
                c_idx_ctrl:     w_rd_data = {30'd0, r_irq_en, r_timer_en};
                default:        w_rd_data = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack      <= 1'b0;
            r_rdt      <= 32'd0;
            r_gpio_out <= '0;
            r_gpio_s1  <= '0;
            r_gpio_s2  <= '0;
            r_mtime    <= 64'd0;
            r_mtimecmp <= {64{1'b1}};
            r_timer_en <= 1'b0;
            r_irq_en   <= 1'b0;
            r_ps       <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_ack      <= w_commit;
            // Read data only lives during the ack clock.
            r_rdt      <= w_commit ? w_rd_data : 32'd0;
            r_gpio_s1  <= i_gpio;
            r_gpio_s2  <= r_gpio_s1;
            if (w_wr_gpio) begin
                r_gpio_out <= w_gpio_wdata[GPIO_W-1:0];
            end
            if (w_wr_ctrl) begin
                r_timer_en <= i_dbus_dat[0];
                r_irq_en   <= i_dbus_dat[1];
            end
            r_ps       <= w_ps_nxt;
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_irq      <= r_irq_en & (r_mtime >= r_mtimecmp);
        end
    end

    assign o_dbus_ack  = r_ack;
    assign o_dbus_rdt  = r_rdt;
    assign o_gpio      = r_gpio_out;
    assign o_timer_irq = r_irq;

    // Address bits outside the decode and the discarded upper GPIO merge bits.
    logic w_unused;
    assign w_unused = ^{i_dbus_adr, w_gpio_wdata};

endmodule
`default_nettype wire

// File: tb/tb_serv_dbus_periph.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serv_dbus_periph
//  Purpose  : Directed self-checking bench for serv_dbus_periph
//             (GPIO_W=3, SEL_BIT=8, PRESCALE=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serv_dbus_periph;

    logic        clk;
    logic        rst;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we;
    logic        dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [2:0]  gpio_in;
    logic [2:0]  gpio_out;
    logic        timer_irq;

    int n_cmp;
    int n_err;

    serv_dbus_periph #(
        .GPIO_W   (3),
        .SEL_BIT  (8),
        .PRESCALE (4)
    ) dut (
        .clk         (clk),
        .i_rst       (rst),
        .i_dbus_adr  (dbus_adr),
        .i_dbus_dat  (dbus_dat),
        .i_dbus_sel  (dbus_sel),
        .i_dbus_we   (dbus_we),
        .i_dbus_cyc  (dbus_cyc),
        .o_dbus_rdt  (dbus_rdt),
        .o_dbus_ack  (dbus_ack),
        .i_gpio      (gpio_in),
        .o_gpio      (gpio_out),
        .o_timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // One bus transaction, started just after a clock edge. Returns the read
    // data seen with ack, the number of clocks until ack, and ack one clock
    // later. Returns just after the clock following the ack.
    task automatic bus(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we,
                       output logic [31:0] rdt, output int lat,
                       output logic ack_after);
        dbus_adr = adr;
        dbus_dat = dat;
        dbus_sel = sel;
        dbus_we  = we;
        dbus_cyc = 1'b1;
        lat = 0;
        while (lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (dbus_ack) break;
        end
        if (!dbus_ack) begin
            lat = 99;
            n_cmp++;
            n_err++;
            $display("FAIL bus_timeout: adr %h got no ack, want ack within 8 clocks", adr);
        end
        rdt = dbus_rdt;
        dbus_cyc = 1'b0;
        dbus_we  = 1'b0;
        @(posedge clk); #1;
        ack_after = dbus_ack;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] r; int l; logic a;
        bus(adr, dat, sel, 1'b1, r, l, a);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] v);
        int l; logic a;
        bus(adr, 32'd0, 4'hF, 1'b0, v, l, a);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        logic [31:0] v;
        #2;
        n_cmp++; if (dbus_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", dbus_ack); end
        n_cmp++; if (dbus_rdt !== 32'd0) begin n_err++; $display("FAIL rst_rdt: got %h want 0", dbus_rdt); end
        n_cmp++; if (gpio_out !== 3'd0) begin n_err++; $display("FAIL rst_gpio: got %b want 000", gpio_out); end
        n_cmp++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", timer_irq); end
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;
        wr(32'h100, 32'h7, 4'hF);
        n_cmp++; if (gpio_out !== 3'b111) begin n_err++; $display("FAIL pre_rst_gpio: got %b want 111", gpio_out); end
        // Reset while the ack of a read is on the bus.
        dbus_adr = 32'h110; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_cyc = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (dbus_ack !== 1'b1) begin n_err++; $display("FAIL mid_ack: got %b want 1", dbus_ack); end
        n_cmp++; if (dbus_rdt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mid_rdt: got %h want ffffffff", dbus_rdt); end
        rst = 1'b1; #1;
        n_cmp++; if (dbus_ack !== 1'b0) begin n_err++; $display("FAIL mid_rst_ack: got %b want 0", dbus_ack); end
        n_cmp++; if (dbus_rdt !== 32'd0) begin n_err++; $display("FAIL mid_rst_rdt: got %h want 0", dbus_rdt); end
        n_cmp++; if (gpio_out !== 3'd0) begin n_err++; $display("FAIL mid_rst_gpio: got %b want 000", gpio_out); end
        dbus_cyc = 1'b0; #2; rst = 1'b0;
        @(posedge clk); #1;
        rd(32'h110, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_mtcmp_lo: got %h want ffffffff", v); end
        rd(32'h114, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_mtcmp_hi: got %h want ffffffff", v); end
        rd(32'h118, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL rst_ctrl: got %h want 0", v); end
    endtask

    task automatic test_gpio;
        logic [31:0] v; int lat; logic aa;
        bus(32'h100, 32'h5, 4'hF, 1'b1, v, lat, aa);
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL ack_latency: got %0d want 1", lat); end
        n_cmp++; if (aa !== 1'b0) begin n_err++; $display("FAIL ack_width: ack after pulse got %b want 0", aa); end
        n_cmp++; if (gpio_out !== 3'b101) begin n_err++; $display("FAIL gpio_out: got %b want 101", gpio_out); end
        rd(32'h100, v);
        n_cmp++; if (v !== 32'h5) begin n_err++; $display("FAIL gpio_rd: got %h want 5", v); end
        wr(32'h100, 32'hFFFF_FFFA, 4'hF);
        rd(32'h100, v);
        n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL gpio_upper_bits: got %h want 2", v); end
        wr(32'h100, 32'h0000_0005, 4'hE);
        n_cmp++; if (gpio_out !== 3'b010) begin n_err++; $display("FAIL gpio_bytesel: got %b want 010", gpio_out); end
    endtask

    task automatic test_byte_sel;
        logic [31:0] v; int lat; logic aa;
        wr(32'h118, 32'hFFFF_FF03, 4'h1);
        rd(32'h118, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL ctrl_sel1: got %h want 3", v); end
        wr(32'h118, 32'h0, 4'h2);
        rd(32'h118, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL ctrl_sel2: got %h want 3", v); end
        bus(32'h118, 32'h0, 4'h0, 1'b1, v, lat, aa);
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL sel0_ack: latency got %0d want 1", lat); end
        rd(32'h118, v);
        n_cmp++; if (v !== 32'h3) begin n_err++; $display("FAIL ctrl_sel0: got %h want 3", v); end
        wr(32'h118, 32'h0, 4'hF);
        wr(32'h110, 32'h1234_5678, 4'b0101);
        rd(32'h110, v);
        n_cmp++; if (v !== 32'hFF34_FF78) begin n_err++; $display("FAIL mtcmp_bytesel: got %h want ff34ff78", v); end
    endtask

    task automatic test_timer;
        logic [31:0] v;
        wr(32'h108, 32'h0, 4'hF);
        wr(32'h10C, 32'h0, 4'hF);
        wr(32'h118, 32'h1, 4'hF);                 // enable edge E0
        rd(32'h108, v);                           // sees state after E1
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL mtime_e1: got %h want 0", v); end
        rd(32'h108, v);                           // after E3
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL mtime_e3: got %h want 0", v); end
        rd(32'h108, v);                           // after E5
        n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL mtime_e5: got %h want 1", v); end
        repeat (13) @(posedge clk);
        #1;
        rd(32'h108, v);                           // after E20
        n_cmp++; if (v !== 32'd5) begin n_err++; $display("FAIL mtime_e20: got %h want 5", v); end

        // Carry from LO into HI.
        wr(32'h118, 32'h0, 4'hF);
        wr(32'h10C, 32'h0, 4'hF);
        wr(32'h108, 32'hFFFF_FFFF, 4'hF);
        wr(32'h118, 32'h1, 4'hF);                 // E0
        rd(32'h10C, v);                           // after E1
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL wrap_hi_before: got %h want 0", v); end
        repeat (3) @(posedge clk);
        #1;
        rd(32'h10C, v);                           // after E6
        n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL wrap_hi_after: got %h want 1", v); end
        rd(32'h108, v);                           // after E8: second tick
        n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL wrap_lo_after: got %h want 1", v); end

        // Bus write on a tick edge wins, no carry into HI.
        wr(32'h118, 32'h0, 4'hF);
        wr(32'h10C, 32'h0, 4'hF);
        wr(32'h108, 32'hFFFF_FFFF, 4'hF);
        wr(32'h118, 32'h1, 4'hF);                 // E0
        repeat (2) @(posedge clk);
        #1;
        wr(32'h108, 32'h55, 4'hF);                // commits on E4, a tick edge
        wr(32'h118, 32'h0, 4'hF);
        rd(32'h10C, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL wr_tick_hi: got %h want 0", v); end
        rd(32'h108, v);
        n_cmp++; if (v !== 32'h55) begin n_err++; $display("FAIL wr_tick_lo: got %h want 55", v); end
    endtask

    task automatic test_irq;
        int k;
        wr(32'h118, 32'h0, 4'hF);
        wr(32'h108, 32'h0, 4'hF);
        wr(32'h10C, 32'h0, 4'hF);
        wr(32'h114, 32'h0, 4'hF);
        wr(32'h110, 32'd10, 4'hF);
        n_cmp++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL irq_disabled: got %b want 0", timer_irq); end
        wr(32'h118, 32'h3, 4'hF);                 // E0, returns after E1
        k = 0;
        while (k < 100 && timer_irq !== 1'b1) begin
            @(posedge clk); #1;
            k++;
        end
        // mtime reaches 10 on E40, irq follows on E41.
        n_cmp++; if (k != 40) begin n_err++; $display("FAIL irq_rise: clocks got %0d want 40", k); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (timer_irq !== 1'b1) begin n_err++; $display("FAIL irq_level: got %b want 1", timer_irq); end
        wr(32'h110, 32'd100, 4'hF);
        n_cmp++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL irq_cmp_raise: got %b want 0", timer_irq); end
        wr(32'h110, 32'd5, 4'hF);
        n_cmp++; if (timer_irq !== 1'b1) begin n_err++; $display("FAIL irq_cmp_lower: got %b want 1", timer_irq); end
        wr(32'h118, 32'h1, 4'hF);
        n_cmp++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL irq_en_clear: got %b want 0", timer_irq); end
        wr(32'h118, 32'h0, 4'hF);
    endtask

    task automatic test_miss;
        logic [31:0] v; int lat; logic aa;
        wr(32'h100, 32'h2, 4'hF);
        bus(32'h000, 32'h0, 4'hF, 1'b0, v, lat, aa);
        n_cmp++; if (lat != 1 || v !== 32'd0) begin n_err++; $display("FAIL miss_rd: lat %0d rdt %h want lat 1 rdt 0", lat, v); end
        rd(32'h11C, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL unmapped_rd: got %h want 0", v); end
        wr(32'h000, 32'h7, 4'hF);
        n_cmp++; if (gpio_out !== 3'b010) begin n_err++; $display("FAIL miss_wr: gpio got %b want 010", gpio_out); end
        rd(32'h103, v);
        n_cmp++; if (v !== 32'h2) begin n_err++; $display("FAIL adr_lsb_ignored: got %h want 2", v); end
        gpio_in = 3'b110;
        @(posedge clk); #1;
        rd(32'h104, v);                           // second edge after the step
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL gpio_in_early: got %h want 0", v); end
        rd(32'h104, v);
        n_cmp++; if (v !== 32'h6) begin n_err++; $display("FAIL gpio_in: got %h want 6", v); end
    endtask

    task automatic test_back_to_back;
        wr(32'h100, 32'h5, 4'hF);
        wr(32'h118, 32'h2, 4'hF);
        dbus_adr = 32'h100; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_cyc = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (dbus_ack !== 1'b1 || dbus_rdt !== 32'h5) begin n_err++; $display("FAIL b2b_first: ack %b rdt %h want 1 5", dbus_ack, dbus_rdt); end
        dbus_adr = 32'h118;
        @(posedge clk); #1;
        n_cmp++; if (dbus_ack !== 1'b0 || dbus_rdt !== 32'd0) begin n_err++; $display("FAIL b2b_gap: ack %b rdt %h want 0 0", dbus_ack, dbus_rdt); end
        @(posedge clk); #1;
        n_cmp++; if (dbus_ack !== 1'b1 || dbus_rdt !== 32'h2) begin n_err++; $display("FAIL b2b_second: ack %b rdt %h want 1 2", dbus_ack, dbus_rdt); end
        dbus_cyc = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (dbus_ack !== 1'b0) begin n_err++; $display("FAIL b2b_end: ack %b want 0", dbus_ack); end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        dbus_adr = 32'd0;
        dbus_dat = 32'd0;
        dbus_sel = 4'd0;
        dbus_we  = 1'b0;
        dbus_cyc = 1'b0;
        gpio_in  = 3'd0;
        test_reset;
        test_gpio;
        test_byte_sel;
        test_timer;
        test_irq;
        test_miss;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
